// File: rtl/dsc_par_roberts_cross_pkg.sv
// Shared definitions for the stochastic Roberts-cross gradient block:
// FSM state encoding, mode encodings and default sizing constants.
package dsc_par_roberts_cross_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 2;

endpackage

// File: rtl/dsc_rc_lane.sv
// One stochastic lane: converts the four window pixels to stream bits against
// a shared reference, forms the diagonal XOR differences and combines them.
module dsc_rc_lane
  import dsc_par_roberts_cross_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] pix00,
  input  logic [DATA_WIDTH-1:0] pix01,
  input  logic [DATA_WIDTH-1:0] pix10,
  input  logic [DATA_WIDTH-1:0] pix11,
  input  logic [DATA_WIDTH-1:0] ref_val,
  input  logic                  mode,
  output logic [1:0]            contrib
);

  logic b00, b01, b10, b11;
  logic mx, my;

  // Unipolar encoding: a bit is 1 when the pixel exceeds this lane's reference.
  always_comb begin
    b00 = (pix00 > ref_val);
    b01 = (pix01 > ref_val);
    b10 = (pix10 > ref_val);
    b11 = (pix11 > ref_val);
    mx  = b00 ^ b11;
    my  = b01 ^ b10;
    if (mode == MODE_OR) begin
      contrib = {1'b0, mx | my};
    end else begin
      contrib = {1'b0, mx} + {1'b0, my};
    end
  end

endmodule

// File: rtl/dsc_par_roberts_cross.sv
// Stochastic Roberts-cross gradient magnitude. Each RUN cycle evaluates LANES
// consecutive reference values in parallel and accumulates the lane results
// into a saturating counter; the run covers all 2^DATA_WIDTH references.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; result, sat held from the previous run
// ST_RUN  | sweeping references, accumulating lane contributions
module dsc_par_roberts_cross
  import dsc_par_roberts_cross_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int EARLY_TERM = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] bin_in00,
  input  logic [DATA_WIDTH-1:0] bin_in01,
  input  logic [DATA_WIDTH-1:0] bin_in10,
  input  logic [DATA_WIDTH-1:0] bin_in11,
  output logic [DATA_WIDTH-1:0] bin_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  sat
);

  localparam int SUM_W = $clog2(2 * LANES + 1);
  localparam int EXT_W = DATA_WIDTH + SUM_W;
  localparam logic [DATA_WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [DATA_WIDTH-1:0] LAST_REF = DATA_WIDTH'((1 << DATA_WIDTH) - LANES);
  localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(LANES);
  localparam bit EARLY = (EARLY_TERM != 0);

  state_t                state;
  logic [DATA_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] acc;
  logic                  clip_seen;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] pix00_q, pix01_q, pix10_q, pix11_q;

  logic [1:0]            contrib [LANES];
  logic [SUM_W-1:0]      lane_sum;
  logic [EXT_W-1:0]      acc_ext;
  logic                  clip;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  last;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] ref_k;
    assign ref_k = counter + DATA_WIDTH'(k);

    dsc_rc_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .pix00  (pix00_q),
      .pix01  (pix01_q),
      .pix10  (pix10_q),
      .pix11  (pix11_q),
      .ref_val(ref_k),
      .mode   (mode_q),
      .contrib(contrib[k])
    );
  end

  // Sum the lanes, add to the accumulator and clip; decide whether this is the final cycle.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + SUM_W'(contrib[k]);
    end
    acc_ext  = EXT_W'(acc) + EXT_W'(lane_sum);
    clip     = (acc_ext > EXT_W'(MAX_VAL));
    acc_next = clip ? MAX_VAL : acc_ext[DATA_WIDTH-1:0];
    last     = (counter == LAST_REF) || (EARLY && (acc_next == MAX_VAL));
  end

  // Control FSM with registered outputs; done is a one-cycle pulse on the final accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      counter      <= '0;
      acc          <= '0;
      clip_seen    <= 1'b0;
      mode_q       <= MODE_SUM;
      pix00_q      <= '0;
      pix01_q      <= '0;
      pix10_q      <= '0;
      pix11_q      <= '0;
      bin_data_out <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            pix00_q   <= bin_in00;
            pix01_q   <= bin_in01;
            pix10_q   <= bin_in10;
            pix11_q   <= bin_in11;
            counter   <= '0;
            acc       <= '0;
            clip_seen <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc       <= acc_next;
          clip_seen <= clip_seen | clip;
          counter   <= counter + STEP;
          if (last) begin
            bin_data_out <= acc_next;
            // An early stop only happens at full scale, so it always reports saturation.
            sat          <= clip_seen | clip | (EARLY && (acc_next == MAX_VAL));
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_par_roberts_cross.sv
// Self-checking bench: four instances (different LANES / EARLY_TERM) driven
// one at a time, compared against a reference-sweep model of the gradient.
module tb_dsc_par_roberts_cross;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [7:0] in00, in01, in10, in11;
  logic       start [4];
  logic [7:0] dout  [4];
  logic       busy  [4];
  logic       done  [4];
  logic       sat   [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsc_par_roberts_cross #(.DATA_WIDTH(8), .LANES(2), .EARLY_TERM(1)) u_l2 (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode),
    .bin_in00(in00), .bin_in01(in01), .bin_in10(in10), .bin_in11(in11),
    .bin_data_out(dout[0]), .busy(busy[0]), .done(done[0]), .sat(sat[0]));

  dsc_par_roberts_cross #(.DATA_WIDTH(8), .LANES(4), .EARLY_TERM(1)) u_l4 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode),
    .bin_in00(in00), .bin_in01(in01), .bin_in10(in10), .bin_in11(in11),
    .bin_data_out(dout[1]), .busy(busy[1]), .done(done[1]), .sat(sat[1]));

  dsc_par_roberts_cross #(.DATA_WIDTH(8), .LANES(1), .EARLY_TERM(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start[2]), .mode(mode),
    .bin_in00(in00), .bin_in01(in01), .bin_in10(in10), .bin_in11(in11),
    .bin_data_out(dout[2]), .busy(busy[2]), .done(done[2]), .sat(sat[2]));

  dsc_par_roberts_cross #(.DATA_WIDTH(8), .LANES(8), .EARLY_TERM(0)) u_l8 (
    .clk(clk), .rst(rst), .start(start[3]), .mode(mode),
    .bin_in00(in00), .bin_in01(in01), .bin_in10(in10), .bin_in11(in11),
    .bin_data_out(dout[3]), .busy(busy[3]), .done(done[3]), .sat(sat[3]));

  function automatic int lanes_of(input int i);
    case (i)
      0: return 2;
      1: return 4;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int et_of(input int i);
    return (i == 3) ? 0 : 1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Model: mode 0 from |a-d|+|b-c|; mode 1 counts references inside the union
  // of the two diagonal intervals. Cycle count walks references in groups of l.
  task automatic model(input int l, input int et, input int a, input int b,
                       input int c, input int d, input int md,
                       output int res, output int s, output int cyc);
    int full, cum, lo1, hi1, lo2, hi2;
    lo1 = (a < d) ? a : d;  hi1 = (a < d) ? d : a;
    lo2 = (b < c) ? b : c;  hi2 = (b < c) ? c : b;
    if (md == 0) begin
      full = (hi1 - lo1) + (hi2 - lo2);
    end else begin
      full = 0;
      for (int r = 0; r < 256; r++)
        if ((r >= lo1 && r < hi1) || (r >= lo2 && r < hi2)) full++;
    end
    res = (full > 255) ? 255 : full;
    s   = et ? int'(res == 255) : int'(full > 255);
    cum = 0;
    cyc = 0;
    for (int r = 0; r < 256; r++) begin
      if (md == 0)
        cum += int'(r >= lo1 && r < hi1) + int'(r >= lo2 && r < hi2);
      else
        cum += int'((r >= lo1 && r < hi1) || (r >= lo2 && r < hi2));
      if (r % l == l - 1) begin
        cyc++;
        if (et != 0 && cum >= 255) break;
      end
    end
  endtask

  // Start a run on instance i, scramble the inputs mid-run, wait for done.
  task automatic run(input int i, input int a, input int b, input int c,
                     input int d, input int md,
                     output int res, output int s, output int cyc);
    @(negedge clk);
    in00 = 8'(a); in01 = 8'(b); in10 = 8'(c); in11 = 8'(d); mode = md[0];
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    in00 = 8'($urandom_range(0, 255)); in01 = 8'($urandom_range(0, 255));
    in10 = 8'($urandom_range(0, 255)); in11 = 8'($urandom_range(0, 255));
    mode = ~mode;
    check("busy_after_start", int'(busy[i]), 1);
    cyc = -1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk);
      #1;
      if (done[i]) begin
        cyc = n;
        break;
      end
    end
    if (cyc < 0) check("done_timeout", 0, 1);
    res = int'(dout[i]);
    s   = int'(sat[i]);
  endtask

  // Run against the model, then confirm done was a single-cycle pulse.
  task automatic exec(input string tag, input int i, input int a, input int b,
                      input int c, input int d, input int md);
    int r, s, cyc, er, es, ec;
    model(lanes_of(i), et_of(i), a, b, c, d, md, er, es, ec);
    run(i, a, b, c, d, md, r, s, cyc);
    check({tag, "/result"}, r, er);
    check({tag, "/sat"}, s, es);
    check({tag, "/cycles"}, cyc, ec);
    @(posedge clk);
    #1;
    check({tag, "/done_pulse"}, int'(done[i]), 0);
    check({tag, "/busy_idle"}, int'(busy[i]), 0);
  endtask

  initial begin
    int r, s, cyc, drops, dones;
    rst = 1'b0;
    mode = 1'b0;
    in00 = '0; in01 = '0; in10 = '0; in11 = '0;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_dout", int'(dout[i]), 0);
      check("reset_busy", int'(busy[i]), 0);
      check("reset_done", int'(done[i]), 0);
      check("reset_sat",  int'(sat[i]), 0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Directed cases on the LANES=2 instance
    run(0, 100, 30, 10, 100, 0, r, s, cyc);
    check("basic/result", r, 20);
    check("basic/sat", s, 0);
    check("basic/cycles", cyc, 128);
    run(0, 100, 0, 50, 0, 0, r, s, cyc);
    check("sum_mode/result", r, 150);
    run(0, 100, 0, 50, 0, 1, r, s, cyc);
    check("or_mode/result", r, 100);
    check("or_mode/sat", s, 0);
    run(0, 255, 0, 255, 0, 0, r, s, cyc);
    check("early/result", r, 255);
    check("early/sat", s, 1);
    check("early/cycles", cyc, 64);

    // LANES=4 with start held high across the whole run
    @(negedge clk);
    in00 = 8'd200; in01 = 8'd50; in10 = 8'd50; in11 = 8'd200; mode = 1'b0;
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    in00 = 8'd255; in01 = 8'd0; in10 = 8'd255; in11 = 8'd0;
    drops = 0;
    cyc = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (done[1]) begin
        cyc = n;
        start[1] = 1'b0;
        break;
      end
      if (!busy[1]) drops++;
    end
    check("held_start/result", int'(dout[1]), 0);
    check("held_start/cycles", cyc, 64);
    check("held_start/busy_drops", drops, 0);
    @(posedge clk);
    #1;
    check("held_start/idle_after", int'(busy[1]), 0);

    // Back-to-back: start issued in the done cycle
    run(0, 100, 30, 10, 100, 0, r, s, cyc);
    check("b2b_first/result", r, 20);
    in00 = 8'd255; in01 = 8'd0; in10 = 8'd255; in11 = 8'd0; mode = 1'b0;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    check("b2b/accepted", int'(busy[0]), 1);
    cyc = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (done[0]) begin
        cyc = n;
        break;
      end
    end
    check("b2b_second/cycles", cyc, 64);
    check("b2b_second/result", int'(dout[0]), 255);
    check("b2b_second/sat", int'(sat[0]), 1);

    // Reset asserted in the middle of a run
    @(negedge clk);
    in00 = 8'd100; in01 = 8'd0; in10 = 8'd50; in11 = 8'd0; mode = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst/dout", int'(dout[0]), 0);
    check("midrst/busy", int'(busy[0]), 0);
    check("midrst/done", int'(done[0]), 0);
    check("midrst/sat",  int'(sat[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (done[0] || busy[0]) dones++;
    end
    check("midrst/no_done", dones, 0);
    exec("after_rst", 0, 100, 30, 10, 100, 0);

    // Saturation boundaries on the non-early-terminating LANES=8 instance
    exec("l8_clip", 3, 255, 0, 255, 0, 0);
    exec("l8_exact", 3, 255, 7, 7, 0, 0);
    exec("l8_or_full", 3, 255, 0, 255, 0, 1);

    // Random sweep across lane counts and both modes
    for (int t = 0; t < 24; t++) begin
      int idx;
      case (t % 4)
        0: idx = 2;
        1: idx = 0;
        2: idx = 3;
        default: idx = 1;
      endcase
      exec("random", idx, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), (t / 4) % 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
